// File: rtl/pipe_latch_gen.sv
// Parametrised inter-stage pipeline latch: chained register stages with
// per-stage valid, stall/flush bubble insertion and a sticky halt freeze.
module pipe_latch_gen #(
    parameter int DATA_W   = 96,
    parameter int CTRL_W   = 8,
    parameter int STAGES   = 1,
    parameter int HALT_BIT = 0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              stall,
    input  logic [STAGES-1:0] flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [STAGES-1:0] stage_valid,
    output logic              halted
);

    if (CTRL_W >= DATA_W) begin : g_bad_ctrl_w
        $error("pipe_latch_gen: CTRL_W must be smaller than DATA_W");
    end
    if (HALT_BIT >= CTRL_W) begin : g_bad_halt_bit
        $error("pipe_latch_gen: HALT_BIT must lie inside the control field");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("pipe_latch_gen: STAGES must be in 1..4");
    end

    // Clears the control field while keeping the datapath bits.
    localparam logic [DATA_W-1:0] KEEP_M =
        {{(DATA_W-CTRL_W){1'b1}}, {CTRL_W{1'b0}}};

    logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
    logic [STAGES-1:0]             valid_q, valid_d;
    logic                          halted_q, halted_d;
    logic                          advance;

    // chain[k] is the source feeding stage k.
    logic [STAGES:0][DATA_W-1:0]   chain;
    logic [STAGES:0]               vchain;

    assign chain  = {data_q, in_data};
    assign vchain = {valid_q, in_valid};

    assign advance = (ihit | dhit) & ~stall & ~halted_q;

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        halted_d = halted_q
                 | (valid_q[STAGES-1] & data_q[STAGES-1][HALT_BIT]);
        for (int k = 0; k < STAGES; k++) begin
            if (halted_q) begin
                data_d[k]  = data_q[k];
                valid_d[k] = valid_q[k];
            end else if (flush[k]) begin
                data_d[k]  = data_q[k] & KEEP_M;
                valid_d[k] = 1'b0;
            end else if (advance) begin
                data_d[k]  = vchain[k] ? chain[k] : (chain[k] & KEEP_M);
                valid_d[k] = vchain[k];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            data_q   <= '0;
            valid_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign out_data    = data_q[STAGES-1];
    assign out_valid   = valid_q[STAGES-1];
    assign stage_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pipe_latch_gen.sv
// Bench for pipe_latch_gen: single-stage and three-stage instances driven
// together and compared against a per-edge reference model.
module tb_pipe_latch_gen;

    localparam logic [95:0] CM = 96'hFF;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        ihit = 1'b0, dhit = 1'b0, stall = 1'b0;
    logic        in_valid = 1'b0;
    logic [95:0] in_data = '0;
    logic [0:0]  flush1 = '0;
    logic [2:0]  flush3 = '0;

    logic        ov1, ov3, h1, h3;
    logic [95:0] od1, od3;
    logic [0:0]  sv1;
    logic [2:0]  sv3;

    int nvec = 0;
    int nerr = 0;

    // Reference state: [0] = 1-stage, [1] = 3-stage.
    logic [95:0] md [2][4];
    logic        mv [2][4];
    logic        mh [2];

    always #5 CLK = ~CLK;

    pipe_latch_gen #(.DATA_W(96), .CTRL_W(8), .STAGES(1), .HALT_BIT(0)) u1 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .stall(stall),
        .flush(flush1), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov1), .out_data(od1), .stage_valid(sv1), .halted(h1)
    );

    pipe_latch_gen #(.DATA_W(96), .CTRL_W(8), .STAGES(3), .HALT_BIT(0)) u3 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .stall(stall),
        .flush(flush3), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov3), .out_data(od3), .stage_valid(sv3), .halted(h3)
    );

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            mh[m] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                md[m][k] = '0;
                mv[m][k] = 1'b0;
            end
        end
    endtask

    // One rising edge of an ns-stage latch, from the rules in words.
    task automatic model_upd(input int m, input int ns, input logic [3:0] fl);
        logic [95:0] od [4];
        logic        ov [4];
        logic        go;
        logic        tail_halt;
        logic [95:0] sd;
        logic        sv;
        for (int k = 0; k < 4; k++) begin
            od[k] = md[m][k];
            ov[k] = mv[m][k];
        end
        tail_halt = ov[ns-1] && od[ns-1][0];
        if (!mh[m]) begin
            go = (ihit || dhit) && !stall;
            for (int k = 0; k < ns; k++) begin
                if (k == 0) begin
                    sd = in_data;
                    sv = in_valid;
                end else begin
                    sd = od[k-1];
                    sv = ov[k-1];
                end
                if (fl[k]) begin
                    md[m][k] = od[k] & ~CM;
                    mv[m][k] = 1'b0;
                end else if (go) begin
                    md[m][k] = sv ? sd : (sd & ~CM);
                    mv[m][k] = sv;
                end
            end
        end
        if (tail_halt) mh[m] = 1'b1;
    endtask

    task automatic compare_all();
        chk("s1_data",  od1, md[0][0]);
        chk("s1_valid", {95'b0, ov1}, {95'b0, mv[0][0]});
        chk("s1_sv",    {95'b0, sv1}, {95'b0, mv[0][0]});
        chk("s1_halt",  {95'b0, h1}, {95'b0, mh[0]});
        chk("s3_data",  od3, md[1][2]);
        chk("s3_valid", {95'b0, ov3}, {95'b0, mv[1][2]});
        chk("s3_sv",    {93'b0, sv3}, {93'b0, mv[1][2], mv[1][1], mv[1][0]});
        chk("s3_halt",  {95'b0, h3}, {95'b0, mh[1]});
    endtask

    task automatic step();
        @(posedge CLK);
        model_upd(0, 1, {3'b0, flush1});
        model_upd(1, 3, {1'b0, flush3});
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        model_clear();
        compare_all();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [95:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    initial begin
        logic [95:0] a_tok, x_tok, y_tok, z_tok, s1d, s3d;
        logic [2:0]  s3v;

        model_clear();
        #1;
        do_reset();
        chk("rst_data", od1, 96'h0);
        chk("rst_valid", {95'b0, ov1}, 96'h0);
        chk("rst_halt", {95'b0, h1}, 96'h0);

        // Single pass.
        a_tok = {{11{8'hA5}}, 8'hF0};
        ihit = 1'b1;
        drive(1'b1, a_tok);
        step();
        chk("pass_data", od1, a_tok);
        chk("pass_valid", {95'b0, ov1}, 96'h1);

        // Hit / stall gating.
        x_tok = {88'h1111_2222_3333_4444_5555_66, 8'h12};
        y_tok = {88'h7777_8888_9999_AAAA_BBBB_CC, 8'h34};
        drive(1'b1, x_tok);
        step();
        drive(1'b1, y_tok);
        ihit = 1'b0;
        dhit = 1'b0;
        repeat (3) begin
            step();
            chk("nohit_hold", od1, x_tok);
        end
        dhit  = 1'b1;
        stall = 1'b1;
        step();
        chk("stall_hold", od1, x_tok);
        stall = 1'b0;
        step();
        chk("stall_release", od1, y_tok);

        // Flush bubble under stall.
        z_tok = {88'hDEAD_BEEF_0123_4567_89AB_CD, 8'h3C};
        drive(1'b1, z_tok);
        step();
        stall  = 1'b1;
        flush1 = 1'b1;
        flush3 = 3'b001;
        step();
        chk("flush_valid", {95'b0, ov1}, 96'h0);
        chk("flush_data", od1, z_tok & ~CM);
        stall  = 1'b0;
        flush1 = 1'b0;
        flush3 = 3'b000;
        drive(1'b0, {88'hFACE_0000_1111_2222_3333_44, 8'hFF});
        step();
        chk("bubble_ctrl", od1 & CM, 96'h0);
        chk("bubble_valid", {95'b0, ov1}, 96'h0);

        // Three-stage streaming.
        do_reset();
        ihit = 1'b1;
        dhit = 1'b0;
        drive(1'b1, {80'h0, 8'd1, 8'h02});
        step();
        chk("sv_e1", {93'b0, sv3}, 96'h1);
        drive(1'b1, {80'h0, 8'd2, 8'h02});
        step();
        chk("sv_e2", {93'b0, sv3}, 96'h3);
        drive(1'b1, {80'h0, 8'd3, 8'h02});
        step();
        chk("sv_e3", {93'b0, sv3}, 96'h7);
        chk("lat3_tok1", od3, {80'h0, 8'd1, 8'h02});
        drive(1'b1, {80'h0, 8'd4, 8'h02});
        flush3 = 3'b010;
        step();
        flush3 = 3'b000;
        chk("mid_tok2", od3, {80'h0, 8'd2, 8'h02});
        drive(1'b1, {80'h0, 8'd5, 8'h02});
        step();
        chk("mid_bubble", {95'b0, ov3}, 96'h0);
        drive(1'b1, {80'h0, 8'd6, 8'h02});
        step();
        chk("mid_tok4", od3, {80'h0, 8'd4, 8'h02});
        chk("mid_tok4_v", {95'b0, ov3}, 96'h1);

        // Randomised traffic, halt bit kept clear.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            ihit     = 1'($urandom_range(0, 1));
            dhit     = 1'($urandom_range(0, 3) == 0);
            stall    = 1'($urandom_range(0, 3) == 0);
            flush3   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) flush3 = 3'b000;
            flush1   = flush3[0];
            drive(1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom, $urandom} & ~96'h1);
            step();
        end

        // Halt freeze.
        stall  = 1'b0;
        flush1 = 1'b0;
        flush3 = 3'b000;
        dhit   = 1'b0;
        ihit   = 1'b1;
        do_reset();
        drive(1'b1, {88'h7777_0000_0000_0000_0000_01, 8'h01});
        step();
        drive(1'b1, {88'h0000_0000_0000_0000_0000_02, 8'h02});
        step();
        chk("halt1_set", {95'b0, h1}, 96'h1);
        chk("halt1_data", od1, {88'h0000_0000_0000_0000_0000_02, 8'h02});
        drive(1'b1, {88'h0000_0000_0000_0000_0000_03, 8'h02});
        step();
        chk("halt3_early", {95'b0, h3}, 96'h0);
        step();
        chk("halt3_set", {95'b0, h3}, 96'h1);
        s1d = md[0][0];
        s3d = md[1][2];
        s3v = {mv[1][2], mv[1][1], mv[1][0]};
        flush1 = 1'b1;
        flush3 = 3'b111;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, {$urandom, $urandom, $urandom});
            step();
            chk("frz1_data", od1, s1d);
            chk("frz3_data", od3, s3d);
            chk("frz3_sv", {93'b0, sv3}, {93'b0, s3v});
        end
        flush1 = 1'b0;
        flush3 = 3'b000;
        do_reset();
        chk("unhalt", {95'b0, h3}, 96'h0);
        chk("unhalt_data", od3, 96'h0);

        // Asynchronous reset while full.
        drive(1'b1, {80'h0, 8'hA1, 8'h02});
        step();
        drive(1'b1, {80'h0, 8'hA2, 8'h02});
        step();
        drive(1'b1, {80'h0, 8'hA3, 8'h02});
        step();
        chk("full_sv", {93'b0, sv3}, 96'h7);
        nRST = 1'b0;
        #2;
        chk("arst_data", od3, 96'h0);
        chk("arst_valid", {95'b0, ov3}, 96'h0);
        chk("arst_sv", {93'b0, sv3}, 96'h0);
        chk("arst_halt", {95'b0, h3}, 96'h0);
        chk("arst_data1", od1, 96'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
